inv_shift_rows_stream: RTL and testbench
========================================

# inv_shift_rows_stream

Byte-serial AES InvShiftRows unit for the decryption datapath. It is the inverse of the encrypt-side ShiftRows permutation. It accepts a stream of 16-byte AES state blocks with a valid/ready handshake and buffers each block in a ping-pong pair of 128-bit banks. It emits each block as a 16-byte stream with rows cyclically shifted right: row 1 by 1 byte, row 2 by 2, row 3 by 3. Sustained throughput is 1 byte/cycle.

## Interface
- Nb, 128, state width in bits (fixed)
- BYTE, 8, byte width in bits (fixed)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_byte carries a valid byte
- in_ready  output  1  unit can accept a byte this cycle
- in_byte  input  BYTE  input byte, AES order a0 first (a[r+4c] = row r, column c)
- out_valid  output  1  out_byte is valid
- out_ready  input  1  downstream accepts out_byte this cycle
- out_byte  output  BYTE  output byte, AES order a0 first
- out_last  output  1  high with the 16th byte of each output block

## Operation
- Storage: two banks of 16 bytes, bank[0..1][0..15]. Each bank has a full flag.
- Write side state: wr_bank (1 bit), wr_idx (4 bits).
- Read side state: rd_bank (1 bit), rd_idx (4 bits).
- in_ready = !full[wr_bank].
- Input handshake (in_valid && in_ready): bank[wr_bank][wr_idx] <= in_byte.
  - If wr_idx==15: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
  - Otherwise wr_idx increments.
- out_valid = full[rd_bank] (flag output, no combinational path from inputs).
- out_byte = bank[rd_bank][P(rd_idx)], with P = InvShiftRows source map: out a[r+4c] = in a[r+4((c−r) mod 4)].
  - P(0..15) = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- out_last = out_valid && rd_idx==15.
- Output handshake (out_valid && out_ready): rd_idx increments.
  - If rd_idx==15: full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0.
- Simultaneous write-complete and read-complete in one cycle are legal. They always target different banks, so both flag updates apply independently.
- With both banks full, in_ready=0. in_ready rises the cycle after the read bank drains.
- in_valid gaps and out_ready gaps are allowed anywhere within a block. No block-framing input exists: every 16 accepted bytes form one block.
- Reset: banks cleared to 0, full flags 0, wr_bank=rd_bank=0, wr_idx=rd_idx=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_byte=0x00.
- Reset mid-block discards any partial input block and any undrained output blocks.

## Timing
- All flag and index updates occur on the rising edge of clk. out_byte and out_last are combinational from registered state only.
- Latency: if byte a0 is accepted at cycle t and bytes a1..a15 are accepted on consecutive cycles, out_valid=1 at t+16 with out_byte = a0.
- Hold rule: while out_valid && !out_ready, out_byte and out_last hold stable.
- Back-to-back operation: with in_valid=1 and out_ready=1 continuously, in_ready stays 1 and out_valid stays 1 from t+16 onward, with no bubbles between blocks.
- Capacity: 32 bytes. With out_ready=0, in_ready falls in the cycle after the 32nd byte is accepted.
- Assertions:
  - in_byte is ignored when in_ready=0.
  - in_valid and out_ready are ignored during rst.

## Test plan
- Single block: in_byte 0x00..0x0F on consecutive cycles, out_ready=1 → out_valid rises 16 cycles after the first accept. Output sequence is 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, with out_last only on 03.
- Round trip: feed the ShiftRows image of 0x00..0x0F (00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B) → output is 00..0F in order.
- Streaming: blocks 0x00..0x0F then 0x10..0x1F back-to-back, out_ready=1 → in_ready never drops and output runs 32 consecutive cycles. Second block output is 10 1D 1A 17 14 11 1E 1B 18 15 12 1F 1C 19 16 13.
- Backpressure: out_ready=0 while 33 bytes are offered → in_ready=0 after byte 32, and out_byte holds 0x00 (first block's a0) stable. Then raise out_ready → both blocks drain correctly, and in_ready returns 1 the cycle after the first block's out_last handshake.
- Random gaps: random in_valid and out_ready duty cycle over 100 blocks → output matches the reference permutation with no loss or duplication.
- Reset mid-operation: accept 7 bytes, assert rst for 1 cycle, then send block 0x20..0x2F → outputs at reset are in_ready=1, out_valid=0, out_byte=0x00. Only the block 20 2D 2A 27 24 21 2E 2B 28 25 22 2F 2C 29 26 23 is emitted.

Source files
------------

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: a ping-pong pair of 16-byte banks fills in
// AES byte order and each full bank is read back through the inverse
// row-rotation map, giving 1 byte/cycle sustained with no bubbles.
module inv_shift_rows_stream #(
  parameter int NB   = 128,
  parameter int BYTE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [BYTE-1:0] in_byte_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [BYTE-1:0] out_byte_o,
  output logic            out_last_o
);
  localparam int NBYTES = NB / BYTE;
  localparam int IDXW   = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  logic [1:0][NBYTES-1:0][BYTE-1:0] bank_q;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic [IDXW-1:0] rd_idx_q, rd_idx_d;
  logic            in_fire, out_fire;
  logic [1:0]      src_col;
  logic [IDXW-1:0] src_idx;

  assign in_ready_o  = !full_q[wr_bank_q];
  assign out_valid_o = full_q[rd_bank_q];
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  // Inverse row rotation: output a[r+4c] comes from a[r+4((c-r) mod 4)].
  // With idx = {c, r}, the source column is just a 2-bit wrapping subtract.
  always_comb begin
    src_col = rd_idx_q[3:2] - rd_idx_q[1:0];
    src_idx = {src_col, rd_idx_q[1:0]};
  end

  assign out_byte_o = bank_q[rd_bank_q][src_idx];
  assign out_last_o = out_valid_o && (rd_idx_q == LAST_IDX);

  // Next-state for flags and pointers; write-complete and read-complete always
  // hit different banks, so both flag updates can apply in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    if (in_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (out_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end
  end

  // State registers; reset wipes banks so out_byte reads 0 until new data lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q    <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      if (in_fire) bank_q[wr_bank_q][wr_idx_q] <= in_byte_i;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed bench for inv_shift_rows_stream: hand-computed byte sequences,
// streaming, backpressure, random gaps and mid-block reset.
module tb_inv_shift_rows_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inv_shift_rows_stream dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_byte_i  (in_byte),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_byte_o (out_byte),
    .out_last_o (out_last)
  );

  // Hand-derived expected sequences
  logic [7:0] exp_single[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                 8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] exp_blk2[16]   = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                                 8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};
  logic [7:0] exp_blk20[16]  = '{8'h20, 8'h2D, 8'h2A, 8'h27, 8'h24, 8'h21, 8'h2E, 8'h2B,
                                 8'h28, 8'h25, 8'h22, 8'h2F, 8'h2C, 8'h29, 8'h26, 8'h23};
  logic [7:0] sr_image[16]   = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                 8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  int         p_tbl[16]      = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         first_in, first_out;
  bit         ready_drop, out_bubble, timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives src_q with the given duty cycles and collects accepted outputs.
  task automatic run(input int in_pct, input int out_pct, input int n_out, input int max_cyc);
    int ii;
    int cyc;
    ii = 0;
    cyc = 0;
    got_q.delete();
    last_q.delete();
    first_in = -1;
    first_out = -1;
    ready_drop = 0;
    out_bubble = 0;
    while (got_q.size() < n_out && cyc < max_cyc) begin
      in_valid  = (ii < src_q.size()) && ($urandom_range(1, 100) <= in_pct);
      in_byte   = (ii < src_q.size()) ? src_q[ii] : 8'h00;
      out_ready = ($urandom_range(1, 100) <= out_pct);
      if (in_valid && in_ready) begin
        if (first_in < 0) first_in = cyc;
        ii++;
      end
      if (!in_ready && ii < src_q.size()) ready_drop = 1;
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
      end else if (first_out >= 0) begin
        out_bubble = 1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        last_q.push_back(out_last);
      end
      tick();
      cyc++;
    end
    timed_out = (got_q.size() < n_out);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_byte = 8'hA5;
    repeat (3) tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    n_chk++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte got %h exp 00", out_byte); end
  endtask

  task automatic test_single();
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    run(100, 100, 16, 100);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL single_timeout got %0d bytes exp 16", got_q.size()); end
    n_chk++;
    if (first_out - first_in !== 16) begin
      n_fail++; $display("FAIL single_latency got %0d exp 16", first_out - first_in);
    end
    if (!timed_out) begin
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (got_q[i] !== exp_single[i]) begin
          n_fail++; $display("FAIL single_byte[%0d] got %h exp %h", i, got_q[i], exp_single[i]);
        end
        n_chk++;
        if (last_q[i] !== (i == 15)) begin
          n_fail++; $display("FAIL single_last[%0d] got %b exp %b", i, last_q[i], i == 15);
        end
      end
    end
  endtask

  task automatic test_round_trip();
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(sr_image[i]);
    run(100, 100, 16, 100);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL rtrip_timeout got %0d bytes exp 16", got_q.size()); end
    if (!timed_out) begin
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (got_q[i] !== 8'(i)) begin
          n_fail++; $display("FAIL rtrip_byte[%0d] got %h exp %h", i, got_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    src_q.delete();
    for (int i = 0; i < 32; i++) src_q.push_back(8'(i));
    run(100, 100, 32, 200);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes exp 32", got_q.size()); end
    n_chk++; if (ready_drop) begin n_fail++; $display("FAIL b2b_in_ready got dropped exp steady 1"); end
    n_chk++; if (out_bubble) begin n_fail++; $display("FAIL b2b_out_valid got bubble exp 32 contiguous"); end
    n_chk++;
    if (first_out - first_in !== 16) begin
      n_fail++; $display("FAIL b2b_latency got %0d exp 16", first_out - first_in);
    end
    if (!timed_out) begin
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (got_q[i] !== exp_single[i] || got_q[16+i] !== exp_blk2[i]) begin
          n_fail++;
          $display("FAIL b2b_byte[%0d] got %h/%h exp %h/%h", i, got_q[i], got_q[16+i], exp_single[i], exp_blk2[i]);
        end
      end
      n_chk++;
      if (last_q[15] !== 1'b1 || last_q[31] !== 1'b1 || last_q[14] !== 1'b0 || last_q[16] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_last got %b%b%b%b exp 0101", last_q[14], last_q[15], last_q[16], last_q[31]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int cyc;
    int n;
    bit chk_next;
    acc = 0; cyc = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    while (acc < 32 && cyc < 100) begin
      in_byte = 8'(acc);
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    n_chk++; if (acc != 32) begin n_fail++; $display("FAIL bp_accepted got %0d exp 32", acc); end
    // 33rd byte offered while full: must be ignored
    in_byte = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_byte !== 8'h00 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got rdy=%b vld=%b byte=%h last=%b exp 0 1 00 0", k, in_ready, out_valid, out_byte, out_last);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    got_q.delete();
    n = 0; cyc = 0; chk_next = 0;
    while (n < 32 && cyc < 200) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        if (n == 15) begin
          n_chk++;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_last got %b exp 0", in_ready); end
          chk_next = 1;
        end
        n++;
      end
      tick();
      cyc++;
      if (chk_next) begin
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_last got %b exp 1", in_ready); end
        chk_next = 0;
      end
    end
    out_ready = 1'b0;
    n_chk++; if (n != 32) begin n_fail++; $display("FAIL bp_drain_count got %0d exp 32", n); end
    if (n == 32) begin
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (got_q[i] !== exp_single[i] || got_q[16+i] !== exp_blk2[i]) begin
          n_fail++;
          $display("FAIL bp_byte[%0d] got %h/%h exp %h/%h", i, got_q[i], got_q[16+i], exp_single[i], exp_blk2[i]);
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    int errs;
    int lerrs;
    int first_bad;
    logic [7:0] e;
    src_q.delete();
    for (int i = 0; i < 1600; i++) src_q.push_back(8'($urandom));
    run(60, 60, 1600, 20000);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout got %0d bytes exp 1600", got_q.size()); end
    errs = 0; lerrs = 0; first_bad = -1;
    if (!timed_out) begin
      for (int b = 0; b < 100; b++) begin
        for (int i = 0; i < 16; i++) begin
          e = src_q[16*b + p_tbl[i]];
          if (got_q[16*b+i] !== e) begin
            errs++;
            if (first_bad < 0) first_bad = 16*b + i;
          end
          if (last_q[16*b+i] !== (i == 15)) lerrs++;
        end
      end
      n_chk++;
      if (errs != 0) begin n_fail++; $display("FAIL rand_data got %0d bad bytes (first at %0d) exp 0", errs, first_bad); end
      n_chk++;
      if (lerrs != 0) begin n_fail++; $display("FAIL rand_last got %0d bad flags exp 0", lerrs); end
    end
  endtask

  task automatic test_mid_reset();
    int acc;
    int extra;
    acc = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 20 && acc < 7; k++) begin
      in_byte = 8'hC0 + 8'(acc);
      if (in_ready) acc++;
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_byte = 8'h77;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_byte !== 8'h00) begin
      n_fail++; $display("FAIL mrst_outputs got rdy=%b vld=%b byte=%h exp 1 0 00", in_ready, out_valid, out_byte);
    end
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'h20 + 8'(i));
    run(100, 100, 16, 100);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL mrst_timeout got %0d bytes exp 16", got_q.size()); end
    if (!timed_out) begin
      for (int i = 0; i < 16; i++) begin
        n_chk++;
        if (got_q[i] !== exp_blk20[i]) begin
          n_fail++; $display("FAIL mrst_byte[%0d] got %h exp %h", i, got_q[i], exp_blk20[i]);
        end
      end
    end
    extra = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) extra++;
      tick();
    end
    out_ready = 1'b0;
    n_chk++; if (extra != 0) begin n_fail++; $display("FAIL mrst_extra_out got %0d bytes exp 0", extra); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
    tick();
    test_reset();
    test_single();
    test_round_trip();
    test_back_to_back();
    test_backpressure();
    test_random_gaps();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
